// File: rtl/mips_mem_sequencer.sv
// Memory sequencer for a single-cycle MIPS datapath sharing one variable-latency memory port.
// Optional bus timeout and HALT state are enabled with `define MEM_TIMEOUT_EN.
module mips_mem_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] Instr,
    output logic [DATA_W-1:0] ReadData,
    output logic              cpu_en,
    output logic [31:0]       retired,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    if (TMO_CYC < 1) begin : g_tmo_check
        $error("TMO_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DATA,
        COMMIT
`ifdef MEM_TIMEOUT_EN
        , HALT
`endif
    } state_t;

    state_t state;
    state_t next_state;
    logic   is_write;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    assign timeout = mem_req && !mem_ack && (wait_cnt == CNT_W'(TMO_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    next_state = EXEC;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    next_state = HALT;
                end
`endif
            end
            EXEC: begin
                if (MemWrite || MemRead) begin
                    next_state = DATA;
                end else begin
                    next_state = FETCH;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    next_state = COMMIT;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    next_state = HALT;
                end
`endif
            end
            COMMIT: next_state = FETCH;
`ifdef MEM_TIMEOUT_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Request lines derive from state only, so they are stable for the whole wait.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_en    = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = PC;
            end
            EXEC: begin
                cpu_en = !MemWrite && !MemRead;
            end
            DATA: begin
                mem_req  = 1'b1;
                mem_we   = is_write;
                mem_addr = ALUOut;
                if (is_write) begin
                    mem_wdata = WriteData;
                end
            end
            COMMIT: begin
                cpu_en = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Direction is captured at decode time; a store wins over a load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            is_write <= 1'b0;
        end else if (state == EXEC) begin
            is_write <= MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Instr    <= '0;
            ReadData <= '0;
            retired  <= '0;
        end else begin
            if (state == FETCH && mem_ack) begin
                Instr <= mem_rdata;
            end
            if (state == DATA && mem_ack && !is_write) begin
                ReadData <= mem_rdata;
            end
            if (cpu_en) begin
                retired <= retired + 32'd1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Self-checking bench for mips_mem_sequencer: random memory latency and instruction mix
// checked against a per-instruction behavioural model (latency, transfers, data, counters).
module tb_mips_mem_sequencer;

    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] PC, ALUOut, WriteData;
    logic          MemRead, MemWrite;
    logic [DW-1:0] Instr, ReadData;
    logic          cpu_en;
    logic [31:0]   retired;
    logic          bus_err;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_ack;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    txn_t        log_q[$];
    int          wait_q[$];

    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    int          stable_err = 0;
    int          post_ack_err = 0;
    logic [31:0] ref_ret;
    logic [31:0] ref_rd;

    always #5 clk = ~clk;

    mips_mem_sequencer #(.DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .PC        (PC),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Instr     (Instr),
        .ReadData  (ReadData),
        .cpu_en    (cpu_en),
        .retired   (retired),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Memory responder: per-transfer wait states come from wait_q; completed transfers are logged.
    initial begin
        logic prev_req;
        logic in_txn;
        logic done;
        int   waits_left;
        txn_t cur;
        txn_t now_t;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        prev_req   = 1'b0;
        in_txn     = 1'b0;
        waits_left = 0;
        cur        = '0;
        forever begin
            @(negedge clk);
            done = prev_req && (mem_ack === 1'b1);
            if (done) begin
                if (cur.we) mem[cur.addr[9:2]] = cur.wdata;
                log_q.push_back(cur);
                in_txn = 1'b0;
                if (mem_req === 1'b1) post_ack_err++;
            end
            if (mem_req === 1'b1 && !done) begin
                now_t = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    cur        = now_t;
                    waits_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end else if (now_t !== cur) begin
                    stable_err++;
                end
                if (waits_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    waits_left--;
                end
            end else begin
                in_txn    = 1'b0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            prev_req = (mem_req === 1'b1);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at #1 after the edge that moves the DUT from IDLE into FETCH.
    task automatic releaseReset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction at the current PC. kind: 0 ALU, 1 load, 2 store, 3 load+store flags.
    task automatic applyStimulus(input int kind, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int w);
        logic [31:0] instr;
        logic        is_mem;
        logic        is_wr;
        logic        got;
        int          n;
        int          exp_cycles;
        instr  = $urandom;
        is_mem = (kind != 0);
        is_wr  = (kind >= 2);
        mem[PC[9:2]] = instr;
        ALUOut    = addr;
        WriteData = wdata;
        MemRead   = (kind == 1 || kind == 3);
        MemWrite  = is_wr;
        exp_cycles = is_mem ? (4 + 2 * w) : (2 + w);
        if (kind == 1) ref_rd = ref_mem[addr[9:2]];
        if (is_wr) ref_mem[addr[9:2]] = wdata;
        log_q.delete();
        wait_q.push_back(w);
        if (is_mem) wait_q.push_back(w);

        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            n++;
            if (cpu_en === 1'b1) got = 1'b1;
        end
        checkOutput("commit_seen", 32'(got), 32'd1);
        checkOutput("cycles_to_commit", 32'(n), 32'(exp_cycles));
        checkOutput("instr", Instr, instr);
        checkOutput("readdata", ReadData, ref_rd);

        @(posedge clk);
        #1;
        ref_ret = ref_ret + 32'd1;
        checkOutput("retired", retired, ref_ret);
        checkOutput("xfer_count", 32'(log_q.size()), is_mem ? 32'd2 : 32'd1);
        if (log_q.size() >= 1) begin
            checkOutput("fetch_addr", log_q[0].addr, PC);
            checkOutput("fetch_we", 32'(log_q[0].we), 32'd0);
        end
        if (is_mem && log_q.size() == 2) begin
            checkOutput("data_addr", log_q[1].addr, addr);
            checkOutput("data_we", 32'(log_q[1].we), 32'(is_wr));
            if (is_wr) checkOutput("data_wdata", log_q[1].wdata, wdata);
        end
        PC = PC + 32'd4;
    endtask

    initial begin
        int req_cycles;
        int stray;
        logic got;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        reset_n = 1'b0;
        PC = '0; ALUOut = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        ref_ret = '0;
        ref_rd  = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_instr", Instr, 32'd0);
        checkOutput("rst_readdata", ReadData, 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        releaseReset();

        $display("[TB] three ALU instructions, zero wait states");
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 0);
        checkOutput("retired_after_3", retired, 32'd3);

        $display("[TB] directed load/store cases");
        mem[32'h100 >> 2]     = 32'hDEADBEEF;
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        applyStimulus(1, 32'h100, 32'h0, 3);
        checkOutput("lw_deadbeef", ReadData, 32'hDEADBEEF);
        applyStimulus(2, 32'h40, 32'h12345678, 1);
        applyStimulus(3, 32'h200, 32'hCAFEF00D, 0);
        applyStimulus(1, 32'h40, 32'h0, 0);
        checkOutput("lw_after_sw", ReadData, 32'h12345678);

        $display("[TB] random instruction mix and latency");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), {22'd0, 8'($urandom_range(64, 255)), 2'b00},
                          $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] retired counter wrap");
        force dut.retired = 32'hFFFFFFFF;
        #1 release dut.retired;
        ref_ret = 32'hFFFFFFFF;
        applyStimulus(0, 32'h0, 32'h0, 0);
        checkOutput("retired_wrap", retired, 32'd0);
        checkOutput("bus_err_clear", 32'(bus_err), 32'd0);

        $display("[TB] reset during a stalled data write");
        mem[PC[9:2]] = $urandom;
        ALUOut = 32'h80; WriteData = $urandom; MemRead = 1'b1; MemWrite = 1'b1;
        log_q.delete();
        wait_q.push_back(0);
        wait_q.push_back(50);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) got = 1'b1;
        end
        checkOutput("reach_data_write", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("midrst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("midrst_retired", retired, 32'd0);
        checkOutput("midrst_instr", Instr, 32'd0);
        checkOutput("midrst_readdata", ReadData, 32'd0);
        @(negedge clk);
        checkOutput("midrst_xfers", 32'(log_q.size()), 32'd1);
        wait_q.delete();
        PC = '0; ref_ret = '0; ref_rd = '0;
        releaseReset();
        applyStimulus(0, 32'h0, 32'h0, 1);
        applyStimulus(1, 32'h200, 32'h0, 2);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] memory never acknowledges");
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        wait_q.delete();
        wait_q.push_back(1000);
        PC = '0;
        releaseReset();
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) req_cycles++;
            else break;
        end
        checkOutput("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
        checkOutput("tmo_bus_err", 32'(bus_err), 32'd1);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || cpu_en !== 1'b0) stray++;
        end
        checkOutput("halt_quiet", 32'(stray), 32'd0);
        checkOutput("tmo_bus_err_sticky", 32'(bus_err), 32'd1);
`else
        req_cycles = 0;
        stray      = 0;
        checkOutput("bus_err_tied", 32'(bus_err), 32'd0);
`endif

        checkOutput("addr_stable_while_waiting", 32'(stable_err), 32'd0);
        checkOutput("req_low_after_ack", 32'(post_ack_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] time limit expired");
    end

endmodule
